// File: rtl/secded_pipe_corrector_if.sv
// Stream bundle for the SEC-DED corrector: the request side carries a stored
// word with its check bits, the response side carries the corrected word and flags.
interface secded_pipe_corrector_if #(
  parameter int DATA_W = 32,
  parameter int CHK_W  = 7
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CHK_W-1:0]  in_chk;
  logic              corr_en;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CHK_W-1:0]  out_syn;
  logic              out_corr;
  logic              out_uncorr;

  modport slave (
    input  in_valid, in_data, in_chk, corr_en, out_ready,
    output in_ready, out_valid, out_data, out_syn, out_corr, out_uncorr
  );

  modport master (
    output in_valid, in_data, in_chk, corr_en, out_ready,
    input  in_ready, out_valid, out_data, out_syn, out_corr, out_uncorr
  );
endinterface

// File: rtl/secded_pipe_corrector.sv
// Two-stage SEC-DED decoder with valid/ready flow control and saturating
// counters of corrected and uncorrectable words delivered downstream.
module secded_pipe_corrector #(
  parameter int DATA_W = 32,
  parameter int HAM_W  = 6,
  parameter int CHK_W  = HAM_W + 1,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  secded_pipe_corrector_if.slave   bus,
  input  logic                     cnt_clr,
  output logic [CNT_W-1:0]         cnt_corr,
  output logic [CNT_W-1:0]         cnt_uncorr
);

  localparam int CW_N = DATA_W + HAM_W;

  // Codeword position of data bit idx: the idx-th non-power-of-two position.
  function automatic int data_pos(input int idx);
    int pos;
    int cnt;
    pos = 0;
    cnt = -1;
    for (int p = 1; p <= CW_N; p++) begin
      if ((p & (p - 1)) != 0) begin
        cnt++;
        if (cnt == idx) pos = p;
      end
    end
    return pos;
  endfunction

  logic              adv;

  logic [HAM_W-1:0]  s1_syn_d;
  logic              s1_par_d;
  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic [HAM_W-1:0]  s1_syn;
  logic              s1_par;
  logic              s1_corr_en;

  logic [DATA_W-1:0] fix_data;
  logic              corr_d;
  logic              uncorr_d;

  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [CHK_W-1:0]  out_syn;
  logic              out_corr;
  logic              out_uncorr;
  logic              out_hs;

  assign adv          = !out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    s1_syn_d = '0;
    for (int d = 0; d < DATA_W; d++) begin
      for (int i = 0; i < HAM_W; i++) begin
        if (((data_pos(d) >> i) & 1) == 1) s1_syn_d[i] = s1_syn_d[i] ^ bus.in_data[d];
      end
    end
    s1_syn_d = s1_syn_d ^ bus.in_chk[HAM_W-1:0];
    s1_par_d = ^{bus.in_data, bus.in_chk};
  end

  // Syndromes of 0 or a power of two never match a data position, so
  // parity/check-bit errors fall through with the data untouched.
  always_comb begin
    fix_data = s1_data;
    corr_d   = 1'b0;
    uncorr_d = 1'b0;
    if (s1_par) begin
      if (int'(s1_syn) > CW_N) begin
        uncorr_d = 1'b1;
      end else begin
        corr_d = 1'b1;
        if (s1_corr_en) begin
          for (int d = 0; d < DATA_W; d++) begin
            if (int'(s1_syn) == data_pos(d)) fix_data[d] = ~s1_data[d];
          end
        end
      end
    end else if (s1_syn != '0) begin
      uncorr_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      s1_syn     <= '0;
      s1_par     <= 1'b0;
      s1_corr_en <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_syn    <= '0;
      out_corr   <= 1'b0;
      out_uncorr <= 1'b0;
    end else if (adv) begin
      // NOTE: non-blocking assignments let stage 2 capture stage 1's old value on the same edge.
      s1_valid   <= bus.in_valid;
      s1_data    <= bus.in_data;
      s1_syn     <= s1_syn_d;
      s1_par     <= s1_par_d;
      s1_corr_en <= bus.corr_en;
      out_valid  <= s1_valid;
      out_data   <= fix_data;
      out_syn    <= {s1_par, s1_syn};
      out_corr   <= corr_d;
      out_uncorr <= uncorr_d;
    end
  end

  assign out_hs = out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else if (cnt_clr) begin
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else if (out_hs) begin
      if (out_corr && (cnt_corr != '1))     cnt_corr   <= cnt_corr + CNT_W'(1);
      if (out_uncorr && (cnt_uncorr != '1)) cnt_uncorr <= cnt_uncorr + CNT_W'(1);
    end
  end

  assign bus.out_valid  = out_valid;
  assign bus.out_data   = out_data;
  assign bus.out_syn    = out_syn;
  assign bus.out_corr   = out_corr;
  assign bus.out_uncorr = out_uncorr;

endmodule
